ir_prefetch_queue: RTL
======================

Name: ir_prefetch_queue

Overview:
- Parametrised successor to the single-entry instruction register.
- Holds a small FIFO of fetched instruction words (opcode + operand) between the MBR and the CU, so memory can fetch ahead while the CU is still executing.
- The head entry drives gated opcode and operand buses to the CU and MBR.
- Adds an explicit push/pop handshake, a branch flush, and head-operand write-back, none of which the single-entry version has.

Parameters:
- OPC_W, 8, opcode field width (upper field of the instruction word).
- OPR_W, 8, operand field width (lower field).
- DEPTH, 2, queue entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_mbr_ir  in  OPC_W+OPR_W  instruction word from MBR; opcode is [OPC_W+OPR_W-1:OPR_W], operand is [OPR_W-1:0].
- i_push  in  1  write strobe; enqueue i_mbr_ir.
- o_ready  out  1  queue can accept a push this cycle.
- i_pop  in  1  CU retires head instruction.
- i_flush  in  1  discard all entries (branch/jump taken).
- i_opr_wr  in  1  overwrite the head operand with i_opr_data.
- i_opr_data  in  OPR_W  operand write-back value (FO stage).
- C14  in  1  opcode output enable.
- C15  in  1  operand output enable.
- o_ir_cu  out  OPC_W  head opcode to CU.
- o_ir_mbr  out  OPR_W  head operand to MBR.
- o_valid  out  1  head entry valid (queue non-empty).
- o_count  out  CNT_W  number of valid entries.

Behaviour:
- Reset (async, i_rst_n=0): all storage, pointers and count go to 0. o_valid=0, o_count=0, o_ir_cu=0, o_ir_mbr=0, o_ready=1.
- Storage: circular buffer with read pointer, write pointer and count; pointers wrap modulo DEPTH.
- o_ready = (count < DEPTH) | (i_pop & o_valid). Combinational; pop and push in the same cycle are allowed when full.
- Push accepted when i_push & o_ready & !i_flush:
  - The entry is written at the write pointer.
  - It becomes visible at the head on the next cycle if the queue was empty (1-cycle latency).
- i_push while !o_ready: ignored; no state change, no overwrite.
- Unlike the single-entry register, zero fields are stored verbatim. There is no "keep old value on zero" rule.
- Pop accepted when i_pop & o_valid & !i_flush: head advances next cycle. i_pop while empty: ignored.
- Simultaneous accepted push and pop: count unchanged, both pointers advance.
- Simultaneous push and pop when count==1: the new word becomes head next cycle; o_valid stays 1.
- i_flush (highest priority): next cycle count=0 and pointers=0. Push, pop and opr_wr in the same cycle are discarded. Storage contents need not be cleared.
- i_opr_wr (when o_valid & !i_flush): writes i_opr_data into the head entry's operand field; the opcode is untouched.
  - If pop is also accepted that cycle, the write is dropped (the head retires).
  - i_opr_wr while empty: ignored.
- Outputs (combinational from head):
  - o_ir_cu = (C14 & o_valid) ? head opcode : 0.
  - o_ir_mbr = (C15 & o_valid) ? head operand : 0.
- o_valid = (count != 0). o_count is registered.
- Reset asserted mid-operation: immediate clear regardless of clock; the first push after release behaves as on an empty queue.

Test Plan:
- Reset, then C14=C15=1 -> o_ir_cu=0x00, o_ir_mbr=0x00, o_valid=0, o_ready=1, o_count=0.
- Push 0x1234 into empty queue, C14=C15=1 -> next cycle o_ir_cu=0x12, o_ir_mbr=0x34, o_count=1. With C14=0, o_ir_cu=0x00.
- Fill (DEPTH=2) with 0x0A01, 0x0B02 -> o_ready=0, o_count=2. Push 0x0C03 without pop -> ignored. Push 0x0C03 with pop -> head 0x0B02 next, count stays 2, then 0x0C03 after a further pop (wrap-around check).
- Push 0x0000 -> stored and presented as opcode 0x00 / operand 0x00; prior contents are not retained.
- Head 0x2055, i_opr_wr with i_opr_data=0xAA -> next cycle o_ir_mbr=0xAA, o_ir_cu=0x20. Repeat with i_pop in the same cycle -> the write is dropped and the next entry surfaces unmodified.
- Queue holds 2 entries; assert i_flush together with i_push of 0x7777 -> next cycle o_count=0, o_valid=0, outputs 0. Async reset pulse mid-stream -> immediate clear.

Source files
------------

// File: rtl/ir_prefetch_queue.sv
// Instruction prefetch FIFO between MBR and CU; the head entry drives gated opcode/operand buses.
// Supports push/pop handshake, branch flush and in-place head-operand write-back.
module ir_prefetch_queue #(
  parameter int OPC_W = 8,
  parameter int OPR_W = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [OPC_W+OPR_W-1:0] i_mbr_ir,
  input  logic                   i_push,
  output logic                   o_ready,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic                   i_opr_wr,
  input  logic [OPR_W-1:0]       i_opr_data,
  input  logic                   C14,
  input  logic                   C15,
  output logic [OPC_W-1:0]       o_ir_cu,
  output logic [OPR_W-1:0]       o_ir_mbr,
  output logic                   o_valid,
  output logic [CNT_W-1:0]       o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [OPC_W-1:0] opc_mem [DEPTH];
  logic [OPR_W-1:0] opr_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic push_ok;
  logic pop_ok;
  logic wr_ok;

  assign o_valid = (count != '0);
  assign o_ready = (count < CNT_W'(DEPTH)) | (i_pop & o_valid);
  assign o_count = count;

  assign push_ok = i_push & o_ready & ~i_flush;
  assign pop_ok  = i_pop & o_valid & ~i_flush;
  // A retiring head makes its operand write-back meaningless, so it is dropped.
  assign wr_ok   = i_opr_wr & o_valid & ~i_flush & ~pop_ok;

  assign o_ir_cu  = (C14 & o_valid) ? opc_mem[rd_ptr] : '0;
  assign o_ir_mbr = (C15 & o_valid) ? opr_mem[rd_ptr] : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head write-back and push never target the same slot: a push into the head
  // slot needs a full queue, which in turn needs a pop that cancels the write-back.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        opc_mem[i] <= '0;
        opr_mem[i] <= '0;
      end
    end else begin
      if (wr_ok) opr_mem[rd_ptr] <= i_opr_data;
      if (push_ok) begin
        opc_mem[wr_ptr] <= i_mbr_ir[OPC_W+OPR_W-1:OPR_W];
        opr_mem[wr_ptr] <= i_mbr_ir[OPR_W-1:0];
      end
    end
  end

endmodule
